// File: rtl/bsg_manycore_xlate_arbiter.sv
// Round-robin arbiter sharing one combinational EVA-to-NPA translator among requesters,
// with a one-entry output register and sticky first-fault capture. Optional fault counter: BSG_MANYCORE_XLATE_FAULT_CNT_EN.
module bsg_manycore_xlate_arbiter #(
    parameter int num_req_p      = 2,
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = 28,
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
`ifdef BSG_MANYCORE_XLATE_FAULT_CNT_EN
    output logic [15:0]                       fault_count_o,
`endif
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*data_width_p-1:0] req_eva_i,
    output logic [num_req_p-1:0]              req_yumi_o,

    output logic [data_width_p-1:0]           xlate_eva_o,
    input  logic [x_cord_width_p-1:0]         xlate_x_cord_i,
    input  logic [y_cord_width_p-1:0]         xlate_y_cord_i,
    input  logic [addr_width_p-1:0]           xlate_epa_i,
    input  logic                              xlate_invalid_i,

    output logic                              v_o,
    output logic [x_cord_width_p-1:0]         x_cord_o,
    output logic [y_cord_width_p-1:0]         y_cord_o,
    output logic [addr_width_p-1:0]           epa_o,
    output logic [$clog2(num_req_p)-1:0]      id_o,
    input  logic                              ready_i,

    output logic                              fault_o,
    output logic [data_width_p-1:0]           fault_eva_o,
    output logic [$clog2(num_req_p)-1:0]      fault_id_o,
    input  logic                              fault_clear_i
);

    localparam int id_width_lp = $clog2(num_req_p);

    logic [data_width_p-1:0]   eva_a [num_req_p];
    logic [id_width_lp-1:0]    last_grant_q;
    logic [id_width_lp-1:0]    grant_id;
    logic                      grant_v;
    logic                      slot_v;

    logic                      v_q;
    logic [x_cord_width_p-1:0] x_q;
    logic [y_cord_width_p-1:0] y_q;
    logic [addr_width_p-1:0]   epa_q;
    logic [id_width_lp-1:0]    id_q;

    logic                      fault_q;
    logic [data_width_p-1:0]   fault_eva_q;
    logic [id_width_lp-1:0]    fault_id_q;
    logic                      fault_set;

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign eva_a[g] = req_eva_i[g*data_width_p +: data_width_p];
    end

    assign slot_v = ~v_q | ready_i;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        logic [id_width_lp-1:0] cand;
        cand     = '0;
        grant_v  = 1'b0;
        grant_id = '0;
        for (int i = 1; i <= num_req_p; i++) begin
            cand = id_width_lp'((int'(last_grant_q) + i) % num_req_p);
            if (!grant_v && req_v_i[cand]) begin
                grant_v  = 1'b1;
                grant_id = cand;
            end
        end
        if (reset_i || !slot_v) begin
            grant_v  = 1'b0;
            grant_id = '0;
        end
    end

    assign req_yumi_o  = grant_v ? ({{(num_req_p-1){1'b0}}, 1'b1} << grant_id) : '0;
    assign xlate_eva_o = eva_a[grant_id];

    // A new fault may overwrite the capture only when none is held or it is being cleared now.
    assign fault_set = grant_v & xlate_invalid_i & (~fault_q | fault_clear_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_q <= id_width_lp'(num_req_p - 1);
            v_q          <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            epa_q        <= '0;
            id_q         <= '0;
            fault_q      <= 1'b0;
            fault_eva_q  <= '0;
            fault_id_q   <= '0;
        end else begin
            if (grant_v) begin
                last_grant_q <= grant_id;
            end
            if (grant_v && !xlate_invalid_i) begin
                v_q   <= 1'b1;
                x_q   <= xlate_x_cord_i;
                y_q   <= xlate_y_cord_i;
                epa_q <= xlate_epa_i;
                id_q  <= grant_id;
            end else if (ready_i) begin
                v_q <= 1'b0;
            end
            if (fault_set) begin
                fault_q     <= 1'b1;
                fault_eva_q <= xlate_eva_o;
                fault_id_q  <= grant_id;
            end else if (fault_clear_i) begin
                fault_q <= 1'b0;
            end
        end
    end

`ifdef BSG_MANYCORE_XLATE_FAULT_CNT_EN
    logic [15:0] fault_cnt_q;
    logic [15:0] fault_cnt_d;

    assign fault_cnt_d = (grant_v && xlate_invalid_i && fault_cnt_q != 16'hFFFF)
                         ? fault_cnt_q + 16'd1 : fault_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fault_cnt_q <= '0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign fault_count_o = fault_cnt_q;
`endif

    assign v_o         = v_q;
    assign x_cord_o    = x_q;
    assign y_cord_o    = y_q;
    assign epa_o       = epa_q;
    assign id_o        = id_q;
    assign fault_o     = fault_q;
    assign fault_eva_o = fault_eva_q;
    assign fault_id_o  = fault_id_q;

endmodule

// File: tb/tb_bsg_manycore_xlate_arbiter.sv
// Scoreboard bench for bsg_manycore_xlate_arbiter (num_req_p=2); the translator is modelled
// as a bit-field slice of the EVA with a bench-driven invalid flag.
module tb_bsg_manycore_xlate_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 28;
    localparam int XW = 7;
    localparam int YW = 7;
    localparam int IW = $clog2(NR);

    typedef struct packed {
        logic [IW-1:0] id;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [AW-1:0] epa;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [NR-1:0] req_v_i;
    logic [DW-1:0] eva0, eva1;
    logic [NR-1:0] req_yumi_o;
    logic [DW-1:0] xlate_eva_o;
    logic [XW-1:0] xlate_x_cord_i;
    logic [YW-1:0] xlate_y_cord_i;
    logic [AW-1:0] xlate_epa_i;
    logic          xlate_invalid_i;
    logic          v_o;
    logic [XW-1:0] x_cord_o;
    logic [YW-1:0] y_cord_o;
    logic [AW-1:0] epa_o;
    logic [IW-1:0] id_o;
    logic          ready_i;
    logic          fault_o;
    logic [DW-1:0] fault_eva_o;
    logic [IW-1:0] fault_id_o;
    logic          fault_clear_i;
`ifdef BSG_MANYCORE_XLATE_FAULT_CNT_EN
    logic [15:0]   fault_count_o;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    always #5 clk_i = ~clk_i;

    assign xlate_x_cord_i = xlate_eva_o[6:0];
    assign xlate_y_cord_i = xlate_eva_o[13:7];
    assign xlate_epa_i    = xlate_eva_o[29:2];

    bsg_manycore_xlate_arbiter #(
        .num_req_p(NR), .data_width_p(DW), .addr_width_p(AW),
        .x_cord_width_p(XW), .y_cord_width_p(YW)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
`ifdef BSG_MANYCORE_XLATE_FAULT_CNT_EN
        .fault_count_o(fault_count_o),
`endif
        .req_v_i(req_v_i),
        .req_eva_i({eva1, eva0}),
        .req_yumi_o(req_yumi_o),
        .xlate_eva_o(xlate_eva_o),
        .xlate_x_cord_i(xlate_x_cord_i),
        .xlate_y_cord_i(xlate_y_cord_i),
        .xlate_epa_i(xlate_epa_i),
        .xlate_invalid_i(xlate_invalid_i),
        .v_o(v_o),
        .x_cord_o(x_cord_o),
        .y_cord_o(y_cord_o),
        .epa_o(epa_o),
        .id_o(id_o),
        .ready_i(ready_i),
        .fault_o(fault_o),
        .fault_eva_o(fault_eva_o),
        .fault_id_o(fault_id_o),
        .fault_clear_i(fault_clear_i)
    );

    function automatic exp_t mk(input int id, input logic [DW-1:0] eva);
        exp_t e;
        e.id  = IW'(id);
        e.x   = eva[6:0];
        e.y   = eva[13:7];
        e.epa = eva[29:2];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    // Result monitor: every handshaken output is matched against the oldest expectation.
    always @(negedge clk_i) begin
        if (!reset_i && v_o && ready_i) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 64'(v_o), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", 64'({id_o, x_cord_o, y_cord_o, epa_o}), 64'(e));
            end
        end
    end

    initial begin
        reset_i = 1'b1; req_v_i = 2'b11; eva0 = '0; eva1 = '0;
        xlate_invalid_i = 1'b0; ready_i = 1'b1; fault_clear_i = 1'b0;

        nxt(); nxt();
        @(negedge clk_i);
        chk("rst_v", 64'(v_o), 64'(0));
        chk("rst_yumi", 64'(req_yumi_o), 64'(0));
        chk("rst_fault", 64'(fault_o), 64'(0));
        chk("rst_outs", 64'({id_o, x_cord_o, y_cord_o, epa_o}), 64'(0));
        chk("rst_fault_cap", 64'({fault_eva_o, fault_id_o}), 64'(0));

        // Alternating grants with both requesters valid
        nxt();
        reset_i = 1'b0; eva0 = 32'h0000_0100; eva1 = 32'h0000_0204;
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back(mk(k % 2, (k % 2 == 1) ? eva1 : eva0));
            @(negedge clk_i);
            chk("rr_yumi", 64'(req_yumi_o), 64'((k % 2 == 1) ? 2'b10 : 2'b01));
            nxt();
        end
        req_v_i = 2'b00;
        @(negedge clk_i);
        chk("idle_yumi", 64'(req_yumi_o), 64'(0));

        // Backpressure: hold result, then refill in the drain cycle
        nxt();
        req_v_i = 2'b10; eva1 = 32'h0000_0308; ready_i = 1'b0;
        sb_q.push_back(mk(1, 32'h0000_0308));
        @(negedge clk_i);
        chk("bp_first_yumi", 64'(req_yumi_o), 64'(2'b10));
        nxt();
        eva1 = 32'h0000_040C;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            chk("bp_hold_yumi", 64'(req_yumi_o), 64'(0));
            chk("bp_hold_out", 64'({v_o, id_o, x_cord_o, epa_o}),
                64'({1'b1, 1'b1, 7'h08, 28'h00000C2}));
            nxt();
        end
        ready_i = 1'b1;
        sb_q.push_back(mk(1, 32'h0000_040C));
        @(negedge clk_i);
        chk("bp_refill_yumi", 64'(req_yumi_o), 64'(2'b10));
        nxt();
        req_v_i = 2'b00;
        @(negedge clk_i);

        // Invalid grant while the previous result drains
        nxt();
        req_v_i = 2'b10; eva1 = 32'h0000_0500;
        sb_q.push_back(mk(1, 32'h0000_0500));
        @(negedge clk_i);
        chk("pre_fault_yumi", 64'(req_yumi_o), 64'(2'b10));
        nxt();
        req_v_i = 2'b01; eva0 = 32'h0000_0004; xlate_invalid_i = 1'b1;
        @(negedge clk_i);
        chk("inv_yumi", 64'(req_yumi_o), 64'(2'b01));
        chk("inv_fault_pending", 64'(fault_o), 64'(0));
        nxt();
        req_v_i = 2'b00; xlate_invalid_i = 1'b0;
        @(negedge clk_i);
        chk("inv_v_cleared", 64'(v_o), 64'(0));
        chk("fault_cap", 64'({fault_o, fault_eva_o, fault_id_o}), 64'({1'b1, 32'h4, 1'b0}));

        // Sticky capture, then clear racing a new fault
        nxt();
        req_v_i = 2'b10; eva1 = 32'h0000_0008; xlate_invalid_i = 1'b1;
        @(negedge clk_i);
        chk("fault2_yumi", 64'(req_yumi_o), 64'(2'b10));
        nxt();
        eva1 = 32'h0000_000C; fault_clear_i = 1'b1;
        @(negedge clk_i);
        chk("fault_sticky", 64'({fault_o, fault_eva_o, fault_id_o}), 64'({1'b1, 32'h4, 1'b0}));
        chk("fault3_yumi", 64'(req_yumi_o), 64'(2'b10));
        nxt();
        req_v_i = 2'b00; xlate_invalid_i = 1'b0; fault_clear_i = 1'b0;
        @(negedge clk_i);
        chk("fault_clr_race", 64'({fault_o, fault_eva_o, fault_id_o}), 64'({1'b1, 32'hC, 1'b1}));
        nxt();
        fault_clear_i = 1'b1;
        nxt();
        fault_clear_i = 1'b0;
        @(negedge clk_i);
        chk("fault_clr", 64'(fault_o), 64'(0));

        // Reset mid-operation drops held result and fault
        nxt();
        req_v_i = 2'b10; eva1 = 32'h0000_0010; xlate_invalid_i = 1'b1;
        @(negedge clk_i);
        nxt();
        req_v_i = 2'b01; eva0 = 32'h0000_0600; xlate_invalid_i = 1'b0; ready_i = 1'b0;
        @(negedge clk_i);
        chk("pre_rst_yumi", 64'(req_yumi_o), 64'(2'b01));
        nxt();
        reset_i = 1'b1; req_v_i = 2'b11;
        @(negedge clk_i);
        chk("pre_rst_state", 64'({v_o, fault_o}), 64'(2'b11));
        chk("rst_no_grant", 64'(req_yumi_o), 64'(0));
        nxt();
        reset_i = 1'b0; ready_i = 1'b1; eva0 = 32'h0000_0700;
        sb_q.push_back(mk(0, 32'h0000_0700));
        @(negedge clk_i);
        chk("post_rst_state", 64'({v_o, fault_o, fault_eva_o}), 64'(0));
        chk("post_rst_yumi", 64'(req_yumi_o), 64'(2'b01));
        nxt();
        req_v_i = 2'b00;
        repeat (3) nxt();

`ifdef BSG_MANYCORE_XLATE_FAULT_CNT_EN
        // Fault counter started from 0 at the last reset
        reset_i = 1'b1;
        nxt();
        reset_i = 1'b0; req_v_i = 2'b01; xlate_invalid_i = 1'b1; ready_i = 1'b1;
        repeat (65537) nxt();
        req_v_i = 2'b00; xlate_invalid_i = 1'b0;
        @(negedge clk_i);
        chk("fault_cnt_sat", 64'(fault_count_o), 64'(16'hFFFF));
        nxt();
`endif

        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_xlate_arbiter.md
BSG_MANYCORE_XLATE_ARBITER -- requirements
Module: bsg_manycore_xlate_arbiter

Interface
REQ-001 The block SHALL have parameter num_req_p, default 2, giving the number of requesters (2..4) sharing one EVA-to-NPA translator.
REQ-002 The block SHALL have parameter data_width_p, default 32: EVA width.
REQ-003 The block SHALL have parameter addr_width_p, default 28: EPA word-address width.
REQ-004 The block SHALL have parameters x_cord_width_p and y_cord_width_p, each default 7: global coordinate widths.
REQ-005 The block SHALL have ports clk_i, input, 1: the single clock; reset_i, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL have ports req_v_i, input, num_req_p, request valid; req_eva_i, input, num_req_p*data_width_p, packed EVAs; req_yumi_o, output, num_req_p, one-hot request consumed.
REQ-007 The block SHALL have translator ports xlate_eva_o, output, data_width_p; xlate_x_cord_i, input, x_cord_width_p; xlate_y_cord_i, input, y_cord_width_p; xlate_epa_i, input, addr_width_p; xlate_invalid_i, input, 1.
REQ-008 The block SHALL have result ports v_o, output, 1; x_cord_o; y_cord_o; epa_o; id_o, output, clog2(num_req_p); ready_i, input, 1.
REQ-009 The block SHALL have fault ports fault_o, output, 1; fault_eva_o, output, data_width_p; fault_id_o, output, clog2(num_req_p); fault_clear_i, input, 1.

Function
REQ-010 Slot-available SHALL be (!v_o | ready_i); with no slot available, req_yumi_o SHALL be all zero.
REQ-011 With a slot available, exactly one valid requester SHALL be granted by round-robin, priority starting at last_grant+1 mod num_req_p.
REQ-012 last_grant SHALL update to the granted index only on a cycle with a grant.
REQ-013 xlate_eva_o SHALL carry the granted requester's EVA, or requester 0's EVA when nothing is granted; the translator is combinational.
REQ-014 A granted valid translation (xlate_invalid_i=0) SHALL load the output register: v_o=1 next cycle, with x/y/epa and id_o = granted index. Latency is one cycle.
REQ-015 Throughput SHALL be one result per cycle while ready_i=1; the output register SHALL be refilled in the same cycle it is drained.
REQ-016 A granted invalid translation SHALL still assert req_yumi_o, SHALL NOT load the output register, and SHALL clear v_o if it was drained that cycle.
REQ-017 On a granted invalid translation with fault_o=0, the block SHALL set fault_o and capture fault_eva_o and fault_id_o next cycle; later faults SHALL NOT overwrite the capture while fault_o=1.
REQ-018 fault_clear_i SHALL clear fault_o next cycle; a simultaneous new fault SHALL win: fault_o stays 1 and the new EVA/id are captured.
REQ-019 While v_o=1 and ready_i=0, x_cord_o, y_cord_o, epa_o and id_o SHALL hold stable.

Reset
REQ-020 While reset_i=1, v_o, fault_o and req_yumi_o SHALL be 0; fault_eva_o, fault_id_o, id_o, x_cord_o, y_cord_o and epa_o SHALL be 0; last_grant SHALL be num_req_p-1.
REQ-021 Reset asserted mid-operation SHALL discard any held result and any captured fault, with no grant in that cycle.

Configuration
REQ-022 With BSG_MANYCORE_XLATE_FAULT_CNT_EN defined, the block SHALL add output fault_count_o, 16 bits: a saturating count of granted invalid translations, reset to 0, not cleared by fault_clear_i.
REQ-023 Without BSG_MANYCORE_XLATE_FAULT_CNT_EN, fault_count_o and its counter SHALL not exist.

Verification
REQ-024 After reset, with num_req_p=2 and both requests valid and ready_i=1 for 4 cycles, grants SHALL be 0,1,0,1 and id_o SHALL be 0,1,0,1 one cycle later.
REQ-025 Requester 1 valid with ready_i=0: the first grant loads v_o=1; req_yumi_o=0 afterwards; the output holds until ready_i=1, then the next grant occurs in that same cycle.
REQ-026 Granted EVA 0x0000_0004 with xlate_invalid_i=1: req_yumi_o=1, v_o stays 0, then fault_o=1, fault_eva_o=0x0000_0004, fault_id_o=granted id.
REQ-027 Second fault with EVA 0x0000_0008 while fault_o=1: capture unchanged; fault_clear_i together with a new fault of EVA 0x0000_000C: fault_o=1, fault_eva_o=0x0000_000C.
REQ-028 reset_i asserted while v_o=1 and fault_o=1: next cycle v_o=0, fault_o=0; first post-reset grant goes to requester 0.
REQ-029 With BSG_MANYCORE_XLATE_FAULT_CNT_EN defined, 65537 invalid grants: fault_count_o SHALL saturate at 0xFFFF.
